// File: rtl/bitstream_generator_window.sv
// Windowed pulse-density source: n ones per period-clock window,
// spread by a Bresenham accumulator, with inhibit/drop tallies.
module bitstream_generator_window #(
  parameter int P_N_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 inh,
  input  logic [P_N_WIDTH-1:0] period,
  input  logic [P_N_WIDTH-1:0] n_req,
  input  logic                 n_req_valid,
  output logic                 n_req_ready,
  output logic                 y,
  output logic                 busy,
  output logic                 update,
  output logic                 valid,
  output logic [P_N_WIDTH-1:0] n_sent,
  output logic [P_N_WIDTH-1:0] n_drop
);

  localparam int W = P_N_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nx;

  logic [W-1:0] per_act, n_act, n_sh;
  logic [W-1:0] cnt, acc, acc_nx;
  logic [W-1:0] sent, drop, sent_nx, drop_nx;
  logic [W-1:0] n_new, per_new, n_clamp;
  logic [W:0]   s;
  logic         pend, first;
  logic         accept, fire, wend, active;

  assign active      = (state != IDLE);
  assign busy        = active;
  assign n_req_ready = !pend;
  assign accept      = n_req_valid && !pend;

  // An accept in the same cycle as a latch point is used at once.
  assign n_new   = accept ? n_req : n_sh;
  assign per_new = (period == '0) ? ONE : period;
  assign n_clamp = (n_new > per_new) ? per_new : n_new;

  assign s    = {1'b0, acc} + {1'b0, n_act};
  assign fire = active && (s >= {1'b0, per_act});
  assign wend = active && (cnt >= per_act - ONE);

  always_comb begin
    acc_nx  = s[W-1:0];
    sent_nx = sent;
    drop_nx = drop;
    if (fire) acc_nx = W'(s - {1'b0, per_act});
    if (fire && !inh && sent != '1) sent_nx = sent + ONE;
    if (fire && inh && drop != '1) drop_nx = drop + ONE;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en) state_nx = RUN;
      RUN:     if (!en) state_nx = wend ? IDLE : DRAIN;
      DRAIN:   if (wend) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      per_act <= '0;
      n_act   <= '0;
      n_sh    <= '0;
      pend    <= 1'b0;
      first   <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      sent    <= '0;
      drop    <= '0;
      y       <= 1'b0;
      update  <= 1'b0;
      valid   <= 1'b0;
      n_sent  <= '0;
      n_drop  <= '0;
    end else begin
      state <= state_nx;
      n_sh  <= n_new;
      if (!active) begin
        y      <= 1'b0;
        update <= 1'b0;
        valid  <= 1'b0;
        first  <= 1'b0;
        pend   <= 1'b0;
        cnt    <= '0;
        acc    <= '0;
        sent   <= '0;
        drop   <= '0;
        if (en) begin
          per_act <= per_new;
          n_act   <= n_clamp;
        end
      end else begin
        y      <= fire && !inh;
        update <= wend;
        if (wend) begin
          cnt     <= '0;
          acc     <= '0;
          sent    <= '0;
          drop    <= '0;
          n_sent  <= sent_nx;
          n_drop  <= drop_nx;
          first   <= 1'b1;
          per_act <= per_new;
          n_act   <= n_clamp;
          pend    <= 1'b0;
          if (first) valid <= 1'b1;
        end else begin
          cnt  <= cnt + ONE;
          acc  <= acc_nx;
          sent <= sent_nx;
          drop <= drop_nx;
          if (accept) pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitstream_generator_window.sv
// Self-checking bench: cycle-level reference model using the closed-form
// placement of ones inside each window, random and directed stimulus.
module tb_bitstream_generator_window;

  logic        clk = 1'b0;
  logic        rst, en, inh, n_req_valid;
  logic [15:0] period, n_req;
  logic        n_req_ready, y, busy, update, valid;
  logic [15:0] n_sent, n_drop;

  int total = 0;
  int bad = 0;

  // reference model: 0 idle, 1 run, 2 drain
  int          m_st;
  longint      m_c, m_per, m_n;
  int unsigned m_sh, m_sent, m_drop;
  bit          m_pend, m_first;
  bit          e_y, e_upd, e_valid;
  int unsigned e_nsent, e_ndrop;

  always #5 clk = ~clk;

  bitstream_generator_window #(.P_N_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .inh(inh),
    .period(period), .n_req(n_req), .n_req_valid(n_req_valid),
    .n_req_ready(n_req_ready), .y(y), .busy(busy),
    .update(update), .valid(valid),
    .n_sent(n_sent), .n_drop(n_drop)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_c = 0; m_per = 1; m_n = 0; m_sh = 0;
    m_sent = 0; m_drop = 0; m_pend = 0; m_first = 0;
    e_y = 0; e_upd = 0; e_valid = 0; e_nsent = 0; e_ndrop = 0;
  endtask

  // Advance the model by one clock with the current inputs, then compare.
  task automatic step();
    bit          acc_ok, fire, wend;
    int unsigned nsh;
    longint      np;
    if (rst) model_reset();
    else begin
      acc_ok = n_req_valid && !m_pend;
      nsh = acc_ok ? int'(n_req) : m_sh;
      np = (period == 0) ? 1 : longint'(period);
      m_sh = nsh;
      if (m_st == 0) begin
        e_y = 0; e_upd = 0; e_valid = 0;
        m_pend = 0; m_first = 0;
        if (en) begin
          m_st = 1; m_c = 0; m_per = np;
          m_n = (nsh > np) ? np : nsh;
          m_sent = 0; m_drop = 0;
        end
      end else begin
        // k-th one lands where floor(c*n/per) steps up
        fire = ((m_c + 1) * m_n) / m_per != (m_c * m_n) / m_per;
        e_y = fire && !inh;
        if (fire && !inh) m_sent++;
        if (fire && inh) m_drop++;
        wend = (m_c == m_per - 1);
        e_upd = wend;
        if (wend) begin
          e_nsent = m_sent; e_ndrop = m_drop;
          m_sent = 0; m_drop = 0; m_c = 0;
          if (m_first) e_valid = 1;
          m_first = 1;
          m_per = np;
          m_n = (nsh > np) ? np : nsh;
          m_pend = 0;
          m_st = (m_st == 1 && en) ? 1 : 0;
        end else begin
          m_c++;
          if (acc_ok) m_pend = 1;
          if (m_st == 1 && !en) m_st = 2;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("y", y, e_y);
    chk("update", update, e_upd);
    chk("valid", valid, e_valid);
    chk("busy", busy, m_st != 0);
    chk("ready", n_req_ready, !m_pend);
    chk("n_sent", n_sent, e_nsent);
    chk("n_drop", n_drop, e_ndrop);
  endtask

  task automatic to_idle();
    en = 0;
    for (int i = 0; i < 40 && m_st != 0; i++) step();
    step();
  endtask

  task automatic wait_c(longint c);
    for (int i = 0; i < 40 && m_c != c; i++) step();
  endtask

  task automatic run_cfg(int p, int n, int cycles);
    period = 16'(p); n_req = 16'(n); n_req_valid = 1;
    step();
    n_req_valid = 0; en = 1;
    repeat (cycles) step();
    to_idle();
  endtask

  initial begin
    int nlist[5];
    rst = 1; en = 0; inh = 0; period = 0; n_req = 0; n_req_valid = 0;
    model_reset();
    repeat (2) step();
    rst = 0;
    step();

    // even spreading
    run_cfg(10, 3, 30);

    // extremes
    run_cfg(10, 0, 25);
    run_cfg(10, 10, 25);
    run_cfg(10, 25, 25);
    run_cfg(0, 3, 6);

    // inhibit over window cycles 0..4
    period = 10; n_req = 5; n_req_valid = 1;
    step();
    n_req_valid = 0; en = 1;
    step();
    repeat (20) begin
      inh = (m_st != 0) && (m_c < 5);
      step();
    end
    inh = 0;

    // handshake: mid-window accept, held-off second request
    wait_c(4);
    n_req = 7; n_req_valid = 1;
    step();
    n_req = 2;
    for (int i = 0; i < 30 && m_pend; i++) step();
    step();
    n_req_valid = 0;
    repeat (25) step();
    // accept coincident with window end
    for (int i = 0; i < 40 && !(m_c == 9 && !m_pend); i++) step();
    n_req = 4; n_req_valid = 1;
    step();
    n_req_valid = 0;
    repeat (20) step();

    // drain from window cycle 4
    wait_c(4);
    to_idle();
    repeat (3) step();

    // reset mid-window with a pending request
    en = 1;
    repeat (3) step();
    n_req = 6; n_req_valid = 1;
    step();
    n_req_valid = 0;
    wait_c(5);
    rst = 1;
    step();
    rst = 0;
    en = 0;
    step();

    // loopback-style window tallies for assorted n
    nlist = '{0, 1, 7, 11, 12};
    foreach (nlist[i]) run_cfg(12, nlist[i], 40);

    // random traffic
    repeat (2500) begin
      en = ($urandom_range(0, 9) != 0);
      inh = ($urandom_range(0, 3) == 0);
      period = 16'($urandom_range(0, 12));
      n_req = 16'($urandom_range(0, 14));
      n_req_valid = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0; n_req_valid = 0; inh = 0;
    to_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
